// File: rtl/sign_conv_pipe_if.sv
// Sample stream bundle for the signed-value conditioner.
// Carries the input and output valid/ready handshakes.
interface sign_conv_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_neg;
  logic             out_ovf;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_neg,
    output out_ovf
  );

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_neg,
    input  out_ovf
  );
endinterface

// File: rtl/sign_conv_pipe.sv
// Two-stage signed-value conditioner for the position datapath.
// Modes: pass, abs, negate, offset-binary to two's complement.
module sign_conv_pipe #(
  parameter int WIDTH = 16,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sign_conv_pipe_if.slave  bus,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             neg;
    logic             ovf;
  } s2_t;

  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V = ~MIN_V;

  logic s1_valid;
  logic s2_valid;
  s1_t  s1_q;
  s2_t  s2_q;
  s2_t  calc;

  logic s1_ld;
  logic s2_ld;
  logic drain;

  logic m_pass;
  logic m_abs;
  logic m_neg;
  logic m_ofs;
  logic msb;
  logic is_min;
  logic [WIDTH-1:0] neg_x;

  assign drain    = s2_valid && bus.out_ready;
  assign s2_ld    = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready =
    !s1_valid || !s2_valid || bus.out_ready;
  assign s1_ld    = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_q.data;
  assign bus.out_neg   = s2_q.neg;
  assign bus.out_ovf   = s2_q.ovf;

  assign m_pass = (s1_q.mode == 2'd0);
  assign m_abs  = (s1_q.mode == 2'd1);
  assign m_neg  = (s1_q.mode == 2'd2);
  assign m_ofs  = (s1_q.mode == 2'd3);
  assign msb    = s1_q.data[WIDTH-1];
  assign is_min = (s1_q.data == MIN_V);
  assign neg_x  = ~s1_q.data + {{(WIDTH-1){1'b0}}, 1'b1};

  // Stage-2 result: only MIN cannot be negated in range
  always_comb begin
    calc.data = s1_q.data;
    calc.neg  = msb;
    calc.ovf  = 1'b0;
    unique case (1'b1)
      m_pass: begin
        calc.data = s1_q.data;
      end
      m_abs: begin
        calc.data = msb ? neg_x : s1_q.data;
        calc.ovf  = is_min;
      end
      m_neg: begin
        calc.data = neg_x;
        calc.ovf  = is_min;
      end
      m_ofs: begin
        calc.data = {~msb, s1_q.data[WIDTH-2:0]};
        calc.neg  = ~msb;
      end
      default: begin
        calc.data = s1_q.data;
      end
    endcase
    if (calc.ovf && (SAT != 0)) begin
      calc.data = MAX_V;
    end
  end

  // Stage 1: capture sample and mode, release on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_ld) begin
      s1_valid <= 1'b1;
      s1_q     <= '{data: bus.in_data,
                    mode: bus.in_mode};
    end else if (s2_ld) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: registered result, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_ld) begin
      s2_valid <= 1'b1;
      s2_q     <= calc;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Overflow events delivered downstream, sticky at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (drain && s2_q.ovf &&
                 (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule
